// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared types and constants for the RV32 execute stage and its
//   iterative multiply/divide unit.
//   Contents: XLEN, ALU op encoding, M-extension op encoding, forwarding
//   select encoding, md FSM state encoding, counter-width helper, and
//   op-class helpers.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } md_op_t;

  typedef enum logic [1:0] {
    FWD_RF, FWD_M, FWD_W
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE, MD_BUSY, MD_DONE
  } md_state_t;

  // Counter must be able to hold DPW itself, hence DPW+1 values.
  function automatic int md_cnt_w(input int dpw);
    return $clog2(dpw + 1);
  endfunction

  localparam int MD_CNT_W = md_cnt_w(XLEN);

  function automatic logic is_mul_op(input md_op_t op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/execute_stage_md_md_unit.sv
// md_unit
//   Iterative RV32M multiply/divide engine: radix-2 shift-add multiplier and
//   restoring divider working on operand magnitudes, one step per cycle.
//   The sign correction is applied combinationally on the DONE result.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     start_i        begin an operation (honoured only in IDLE)
//     flush_i        abort an in-flight operation back to IDLE
//     op_i           M-extension op to start
//     a_i, b_i       forwarded source operands
//     busy_o         FSM is iterating
//     done_o         result_o is valid this cycle
//     result_o       final, sign-corrected result
module md_unit
  import rv32i_pkg::*;
#(
  parameter int DPW = XLEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           flush_i,
  input  md_op_t         op_i,
  input  logic [DPW-1:0] a_i,
  input  logic [DPW-1:0] b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [DPW-1:0] result_o
);

  localparam int CW = md_cnt_w(DPW);
  localparam logic [DPW-1:0] MOST_NEG = {1'b1, {(DPW-1){1'b0}}};

  md_state_t      state_q;
  logic [CW-1:0]  cnt_q;
  md_op_t         op_q;
  logic [DPW-1:0] hi_q, lo_q, b_q;
  logic           negq_q, negr_q;

  // Operand decode at start: which operands are signed, their magnitudes,
  // and the two divide cases that bypass iteration.
  logic           isDivI, signAI, signBI, negA, negB, divZero, divOvf;
  logic [DPW-1:0] magA, magB;
  always_comb begin
    isDivI  = is_div_op(op_i);
    signAI  = op_i inside {MUL, MULH, MULHSU, DIV, REM};
    signBI  = op_i inside {MUL, MULH, DIV, REM};
    negA    = signAI & a_i[DPW-1];
    negB    = signBI & b_i[DPW-1];
    magA    = negA ? -a_i : a_i;
    magB    = negB ? -b_i : b_i;
    divZero = isDivI & (b_i == '0);
    divOvf  = (op_i inside {DIV, REM}) & (a_i == MOST_NEG) & (&b_i);
  end

  // One iteration step. Multiply: {hi,lo} shifts right with the partial sum
  // entering at the top. Divide: hi is the partial remainder, lo shifts the
  // dividend out and quotient bits in; the borrow bit picks restore or not.
  logic [DPW:0]   mulSum, divShift, divDiff;
  logic [DPW-1:0] hi_d, lo_d;
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    divShift = {hi_q, lo_q[DPW-1]};
    divDiff  = divShift - {1'b0, b_q};
    if (is_div_op(op_q)) begin
      if (!divDiff[DPW]) begin
        hi_d = divDiff[DPW-1:0];
        lo_d = {lo_q[DPW-2:0], 1'b1};
      end else begin
        hi_d = divShift[DPW-1:0];
        lo_d = {lo_q[DPW-2:0], 1'b0};
      end
    end else begin
      hi_d = mulSum[DPW:1];
      lo_d = {mulSum[0], lo_q[DPW-1:1]};
    end
  end

  // Result selection with sign fix. negq_q carries the product sign for
  // multiplies and the quotient sign for divides.
  logic [2*DPW-1:0] prodFix;
  always_comb begin
    prodFix  = negq_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    result_o = '0;
    case (op_q)
      MUL:                  result_o = prodFix[DPW-1:0];
      MULH, MULHSU, MULHU:  result_o = prodFix[2*DPW-1:DPW];
      DIV, DIVU:            result_o = negq_q ? -lo_q : lo_q;
      REM, REMU:            result_o = negr_q ? -hi_q : hi_q;
      default:              result_o = '0;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

  // FSM, counter and datapath registers. Special divide cases preload hi/lo
  // so that the ordinary DONE sign fix yields the architected result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            op_q <= op_i;
            b_q  <= magB;
            if (divZero) begin
              hi_q    <= magA;
              lo_q    <= '1;
              negq_q  <= 1'b0;
              negr_q  <= negA;
              cnt_q   <= '0;
              state_q <= MD_DONE;
            end else if (divOvf) begin
              hi_q    <= '0;
              lo_q    <= a_i;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= MD_DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= magA;
              negq_q  <= negA ^ negB;
              negr_q  <= negA;
              cnt_q   <= CW'(DPW);
              state_q <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (flush_i) begin
            state_q <= MD_IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= MD_DONE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md
//   RV32 execute stage with M/W operand forwarding, valid/flush handling and
//   an iterative multiply/divide unit that stalls the front end.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     validE, flushE                 E holds an instruction / kill it
//     regwriteE, resultsrcE,
//     memwriteE                      control passed to M
//     alu_ctrlE, md_opE              ALU op / M-extension op (MD_NONE = ALU)
//     alusrcE                        srcB = immextE when 1
//     fwd_aE, fwd_bE                 forwarding selects for srcA / Rd2
//     Rd1E, Rd2E, immextE, RdE       operands and destination
//     resultW                        writeback value for forwarding
//     stallE                         hold F/D/E
//     validM ... RdM                 E/M pipeline register outputs
module execute_stage_md
  import rv32i_pkg::*;
#(
  parameter int DPW    = XLEN,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           validE,
  input  logic           flushE,
  input  logic           regwriteE,
  input  logic           resultsrcE,
  input  logic           memwriteE,
  input  alu_op_t        alu_ctrlE,
  input  md_op_t         md_opE,
  input  logic           alusrcE,
  input  fwd_sel_t       fwd_aE,
  input  fwd_sel_t       fwd_bE,
  input  logic [DPW-1:0] Rd1E,
  input  logic [DPW-1:0] Rd2E,
  input  logic [DPW-1:0] immextE,
  input  logic [4:0]     RdE,
  input  logic [DPW-1:0] resultW,
  output logic           stallE,
  output logic           validM,
  output logic           regwriteM,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic [DPW-1:0] aluresultM,
  output logic [DPW-1:0] Rd2M,
  output logic [4:0]     RdM
);

  localparam int SHW = $clog2(DPW);

  // Forwarding muxes and the srcB immediate mux.
  logic [DPW-1:0] srcA, rd2Fwd, srcB;
  always_comb begin
    case (fwd_aE)
      FWD_M:   srcA = aluresultM;
      FWD_W:   srcA = resultW;
      default: srcA = Rd1E;
    endcase
    case (fwd_bE)
      FWD_M:   rd2Fwd = aluresultM;
      FWD_W:   rd2Fwd = resultW;
      default: rd2Fwd = Rd2E;
    endcase
  end
  assign srcB = alusrcE ? immextE : rd2Fwd;

  // Single-cycle ALU. Any M-extension encoding that reaches this path
  // (disabled class or not started) produces zero.
  logic [DPW-1:0] aluOut, exResult;
  logic [SHW-1:0] shamt;
  logic           isMdOp;
  always_comb begin
    shamt  = srcB[SHW-1:0];
    aluOut = '0;
    case (alu_ctrlE)
      ALU_ADD:  aluOut = srcA + srcB;
      ALU_SUB:  aluOut = srcA - srcB;
      ALU_AND:  aluOut = srcA & srcB;
      ALU_OR:   aluOut = srcA | srcB;
      ALU_XOR:  aluOut = srcA ^ srcB;
      ALU_SLT:  aluOut = {{(DPW-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluOut = {{(DPW-1){1'b0}}, srcA < srcB};
      ALU_SLL:  aluOut = srcA << shamt;
      ALU_SRL:  aluOut = srcA >> shamt;
      ALU_SRA:  aluOut = $signed(srcA) >>> shamt;
      default:  aluOut = '0;
    endcase
    isMdOp   = is_mul_op(md_opE) | is_div_op(md_opE);
    exResult = isMdOp ? '0 : aluOut;
  end

  // Start/stall handshake. A request is only taken in IDLE, so the DONE
  // cycle (same instruction still in E) never restarts the unit.
  logic           mdEnabled, mdReq, mdIdle, mdStart, mdBusy, mdDone;
  logic [DPW-1:0] mdResult;
  assign mdEnabled = (is_mul_op(md_opE) & MUL_EN) | (is_div_op(md_opE) & DIV_EN);
  assign mdReq     = validE & ~flushE & mdEnabled;
  assign mdIdle    = ~mdBusy & ~mdDone;
  assign mdStart   = mdReq & mdIdle;
  assign stallE    = rst_n & (mdStart | (mdBusy & ~flushE));

  md_unit #(.DPW(DPW)) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdReq),
    .flush_i  (flushE),
    .op_i     (md_opE),
    .a_i      (srcA),
    .b_i      (srcB),
    .busy_o   (mdBusy),
    .done_o   (mdDone),
    .result_o (mdResult)
  );

  // Control and store data of the M-ext instruction, captured at start so
  // forwarding sources may change while the unit iterates.
  logic           mdRegwrite_q, mdResultsrc_q, mdMemwrite_q;
  logic [4:0]     mdRd_q;
  logic [DPW-1:0] mdRd2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdRegwrite_q  <= 1'b0;
      mdResultsrc_q <= 1'b0;
      mdMemwrite_q  <= 1'b0;
      mdRd_q        <= '0;
      mdRd2_q       <= '0;
    end else if (mdStart) begin
      mdRegwrite_q  <= regwriteE;
      mdResultsrc_q <= resultsrcE;
      mdMemwrite_q  <= memwriteE;
      mdRd_q        <= RdE;
      mdRd2_q       <= rd2Fwd;
    end
  end

  // E/M register: bubble while stalled, M-ext result in DONE, otherwise the
  // single-cycle path. A flush in DONE falls through to the single-cycle
  // path with validM cleared, so no result is written.
  logic validNext;
  assign validNext = validE & ~flushE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validM     <= 1'b0;
      regwriteM  <= 1'b0;
      resultsrcM <= 1'b0;
      memwriteM  <= 1'b0;
      aluresultM <= '0;
      Rd2M       <= '0;
      RdM        <= '0;
    end else if (stallE) begin
      validM    <= 1'b0;
      regwriteM <= 1'b0;
      memwriteM <= 1'b0;
    end else if (mdDone && !flushE) begin
      validM     <= 1'b1;
      regwriteM  <= mdRegwrite_q;
      resultsrcM <= mdResultsrc_q;
      memwriteM  <= mdMemwrite_q;
      aluresultM <= mdResult;
      Rd2M       <= mdRd2_q;
      RdM        <= mdRd_q;
    end else begin
      validM     <= validNext;
      regwriteM  <= regwriteE & validNext;
      resultsrcM <= resultsrcE;
      memwriteM  <= memwriteE & validNext;
      aluresultM <= exResult;
      Rd2M       <= rd2Fwd;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md
//   Directed bench: a table of single-cycle ALU/forwarding vectors followed by
//   hand-written multi-cycle sequences for multiply/divide, the special
//   divide cases, flush of an in-flight divide and reset mid-operation.
module tb_execute_stage_md;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validE, flushE, regwriteE, resultsrcE, memwriteE, alusrcE;
  alu_op_t     alu_ctrlE;
  md_op_t      md_opE;
  fwd_sel_t    fwd_aE, fwd_bE;
  logic [31:0] Rd1E, Rd2E, immextE, resultW;
  logic [4:0]  RdE;
  logic        stallE, validM, regwriteM, resultsrcM, memwriteM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;

  int total = 0;
  int bad   = 0;

  execute_stage_md #(.DPW(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .validE     (validE),
    .flushE     (flushE),
    .regwriteE  (regwriteE),
    .resultsrcE (resultsrcE),
    .memwriteE  (memwriteE),
    .alu_ctrlE  (alu_ctrlE),
    .md_opE     (md_opE),
    .alusrcE    (alusrcE),
    .fwd_aE     (fwd_aE),
    .fwd_bE     (fwd_bE),
    .Rd1E       (Rd1E),
    .Rd2E       (Rd2E),
    .immextE    (immextE),
    .RdE        (RdE),
    .resultW    (resultW),
    .stallE     (stallE),
    .validM     (validM),
    .regwriteM  (regwriteM),
    .resultsrcM (resultsrcM),
    .memwriteM  (memwriteM),
    .aluresultM (aluresultM),
    .Rd2M       (Rd2M),
    .RdM        (RdM)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    fwd_sel_t    fa;
    fwd_sel_t    fb;
    logic        alusrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] resW;
    logic        valid;
    logic        flush;
    logic        rw;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] expRes;
    logic [31:0] expRd2;
    logic        expValid;
    logic        expRw;
    logic        expMw;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    validE     = 1'b0;
    flushE     = 1'b0;
    regwriteE  = 1'b0;
    resultsrcE = 1'b0;
    memwriteE  = 1'b0;
    alusrcE    = 1'b0;
    alu_ctrlE  = ALU_ADD;
    md_opE     = MD_NONE;
    fwd_aE     = FWD_RF;
    fwd_bE     = FWD_RF;
    Rd1E       = '0;
    Rd2E       = '0;
    immextE    = '0;
    RdE        = '0;
    resultW    = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    validE     = v.valid;
    flushE     = v.flush;
    regwriteE  = v.rw;
    resultsrcE = 1'b0;
    memwriteE  = v.mw;
    alusrcE    = v.alusrc;
    alu_ctrlE  = v.op;
    md_opE     = MD_NONE;
    fwd_aE     = v.fa;
    fwd_bE     = v.fb;
    Rd1E       = v.rd1;
    Rd2E       = v.rd2;
    immextE    = v.imm;
    RdE        = v.rd;
    resultW    = v.resW;
  endtask

  task automatic applyMd(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    setIdle();
    validE    = 1'b1;
    regwriteE = 1'b1;
    md_opE    = op;
    Rd1E      = a;
    Rd2E      = b;
    RdE       = rd;
  endtask

  task automatic applyAdd(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    setIdle();
    validE    = 1'b1;
    regwriteE = 1'b1;
    Rd1E      = a;
    Rd2E      = b;
    RdE       = rd;
  endtask

  // Issue an M-ext op at posedge+1, count stall cycles (sampled at negedge),
  // confirm M holds bubbles while stalled, then check the written result.
  task automatic runMd(input string name, input md_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expRes, input int expStall);
    int stalls = 0;
    int bubbleBad = 0;
    applyMd(op, a, b, rd);
    @(negedge clk);
    while (stallE && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      if (validM !== 1'b0 || regwriteM !== 1'b0) bubbleBad++;
      @(negedge clk);
    end
    checkOutput({name, " stall cycles"}, stalls, expStall);
    checkOutput({name, " bubble violations"}, bubbleBad, 0);
    @(posedge clk); #1;
    checkOutput({name, " aluresultM"}, aluresultM, expRes);
    checkOutput({name, " validM"}, {31'b0, validM}, 32'd1);
    checkOutput({name, " RdM"}, {27'b0, RdM}, {27'b0, rd});
    checkOutput({name, " regwriteM"}, {31'b0, regwriteM}, 32'd1);
    setIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // op, fa, fb, alusrc, rd1, rd2, imm, resW, valid, flush, rw, mw, rd,
    // expRes, expRd2, expValid, expRw, expMw
    vecs[0]  = '{ALU_ADD,  FWD_RF, FWD_RF, 1'b0, 32'd2, 32'd3, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{ALU_ADD,  FWD_M,  FWD_RF, 1'b1, 32'h11, 32'h22, 32'd3, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'd8, 32'h22, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{ALU_SUB,  FWD_W,  FWD_M,  1'b0, 32'd0, 32'd0, 32'd0, 32'd100,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'd92, 32'd8, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{ALU_AND,  FWD_RF, FWD_RF, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'hF000, 32'hFF00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{ALU_OR,   FWD_RF, FWD_RF, 1'b0, 32'hF0F0, 32'h0F00, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hFFF0, 32'h0F00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{ALU_XOR,  FWD_RF, FWD_RF, 1'b0, 32'hFF00, 32'h0FF0, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 32'hF0F0, 32'h0FF0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{ALU_SLT,  FWD_RF, FWD_RF, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{ALU_SLTU, FWD_RF, FWD_RF, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{ALU_SLL,  FWD_RF, FWD_RF, 1'b1, 32'd1, 32'd7, 32'd4, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'd16, 32'd7, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{ALU_SRL,  FWD_RF, FWD_RF, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 32'h08000000, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{ALU_SRA,  FWD_RF, FWD_RF, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd11, 32'hF8000000, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{ALU_ADD,  FWD_RF, FWD_RF, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0,
                 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{ALU_ADD,  FWD_RF, FWD_RF, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 32'd11, 32'd6, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{ALU_ADD,  FWD_RF, FWD_W,  1'b1, 32'h100, 32'd0, 32'd8, 32'hDEAD,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h108, 32'hDEAD, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{ALU_ADD,  FWD_RF, FWD_M,  1'b0, 32'd1, 32'd0, 32'd0, 32'd0,
                 1'b1, 1'b0, 1'b1, 1'b0, 5'd14, 32'h109, 32'h108, 1'b1, 1'b1, 1'b0};

    // Reset state
    setIdle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset validM", {31'b0, validM}, 32'd0);
    checkOutput("reset aluresultM", aluresultM, 32'd0);
    checkOutput("reset RdM", {27'b0, RdM}, 32'd0);
    checkOutput("reset stallE", {31'b0, stallE}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle table
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d stallE", i), {31'b0, stallE}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d aluresultM", i), aluresultM, vecs[i].expRes);
      checkOutput($sformatf("vec%0d Rd2M", i), Rd2M, vecs[i].expRd2);
      checkOutput($sformatf("vec%0d validM", i), {31'b0, validM}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d regwriteM", i), {31'b0, regwriteM}, {31'b0, vecs[i].expRw});
      checkOutput($sformatf("vec%0d memwriteM", i), {31'b0, memwriteM}, {31'b0, vecs[i].expMw});
      checkOutput($sformatf("vec%0d RdM", i), {27'b0, RdM}, {27'b0, vecs[i].rd});
    end
    setIdle();

    // Multiply / divide sequences
    runMd("MUL 7*-3",        MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    runMd("DIV 100/0",       DIV,    32'd100,      32'd0,        5'd6,  32'hFFFFFFFF, 1);
    runMd("REM 100/0",       REM,    32'd100,      32'd0,        5'd7,  32'd100,      1);
    runMd("DIV ovf",         DIV,    32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 1);
    runMd("REM ovf",         REM,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'd0,        1);
    runMd("MULHU max",       MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 33);
    runMd("MULHSU -1*max",   MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFF, 33);
    runMd("DIV -7/2",        DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, 33);
    runMd("REM -7/2",        REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, 33);

    // Flush an in-flight DIVU, then an ADD must pass straight through
    begin
      int validSeen = 0;
      applyMd(DIVU, 32'd100, 32'd7, 5'd20);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (validM !== 1'b0) validSeen++;
      end
      flushE = 1'b1;
      #2;
      checkOutput("flush cycle stallE", {31'b0, stallE}, 32'd0);
      @(posedge clk); #1;
      if (validM !== 1'b0) validSeen++;
      applyAdd(32'd4, 32'd5, 5'd21);
      #2;
      checkOutput("after flush stallE", {31'b0, stallE}, 32'd0);
      @(posedge clk); #1;
      checkOutput("after flush ADD aluresultM", aluresultM, 32'd9);
      checkOutput("after flush ADD validM", {31'b0, validM}, 32'd1);
      checkOutput("after flush ADD RdM", {27'b0, RdM}, 32'd21);
      setIdle();
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (validM !== 1'b0) validSeen++;
      end
      checkOutput("flushed divide validM pulses", validSeen, 0);
    end

    // Reset in the middle of a MUL
    applyAdd(32'd4, 32'd5, 5'd3);
    @(posedge clk); #1;
    checkOutput("pre-reset ADD aluresultM", aluresultM, 32'd9);
    applyMd(MUL, 32'd3, 32'd4, 5'd9);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset validM", {31'b0, validM}, 32'd0);
    checkOutput("midreset regwriteM", {31'b0, regwriteM}, 32'd0);
    checkOutput("midreset memwriteM", {31'b0, memwriteM}, 32'd0);
    checkOutput("midreset resultsrcM", {31'b0, resultsrcM}, 32'd0);
    checkOutput("midreset aluresultM", aluresultM, 32'd0);
    checkOutput("midreset Rd2M", Rd2M, 32'd0);
    checkOutput("midreset RdM", {27'b0, RdM}, 32'd0);
    checkOutput("midreset stallE", {31'b0, stallE}, 32'd0);
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runMd("DIVU 100/7", DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 33);
    runMd("REMU 100/7", REMU, 32'd100, 32'd7, 5'd15, 32'd2,  33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
